// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state type and helpers for clock-divider arbitration
package clk_div_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, SETTLE, OWNED} state_t;

  localparam int DEF_CLK_DIV_SIZE = 3;
  localparam int MAX_REQ = 8;

  function automatic logic [MAX_REQ-1:0] one_hot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/clk_div_cfg_arbiter_if.sv
// rtl/clk_div_cfg_arbiter_if.sv - requester and divider signals of the divider arbiter
interface clk_div_cfg_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int CLK_DIV_SIZE = clk_div_pkg::DEF_CLK_DIV_SIZE
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ-1:0]              rel;
  logic [NUM_REQ*CLK_DIV_SIZE-1:0] div_req;
  logic                            div_tick;
  logic                            div_wr;
  logic [CLK_DIV_SIZE-1:0]         div_out;
  logic [NUM_REQ-1:0]              grant;
  logic                            ready;
  logic [IDW-1:0]                  owner_id;

  modport master (
    input  req, rel, div_req, div_tick,
    output div_wr, div_out, grant, ready, owner_id
  );

  modport slave (
    output req, rel, div_req, div_tick,
    input  div_wr, div_out, grant, ready, owner_id
  );

endinterface

// File: rtl/clk_div_cfg_arbiter_rr_pick.sv
// rtl/clk_div_cfg_arbiter_rr_pick.sv - round-robin first-set search starting at a pointer
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] sel
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] idx;

  // Scan from farthest to nearest so the nearest set bit is written last.
  always_comb begin
    valid = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        valid = 1'b1;
        sel   = idx;
      end
    end
  end

endmodule

// File: rtl/clk_div_cfg_arbiter.sv
// rtl/clk_div_cfg_arbiter.sv - round-robin owner of a shared clock divider (CLK_DIV_ARB_LEASE_EN adds a lease limit)
module clk_div_cfg_arbiter
  import clk_div_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLK_DIV_SIZE = DEF_CLK_DIV_SIZE,
  parameter int SETTLE_TICKS = 1,
  parameter int LEASE_TICKS  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clk_div_cfg_arbiter_if.master bus
);
  localparam int IDW = $clog2(NUM_REQ);

  state_t                  state, state_nxt;
  logic [IDW-1:0]          rr_ptr, owner_id, sel;
  logic                    pick_valid;
  logic [2:0]              settle_cnt;
  logic [CLK_DIV_SIZE-1:0] cur_div, sel_div;
  logic                    owner_req, owner_rel, settle_done, lease_done;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .sel   (sel)
  );

  always_comb begin
    sel_div = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (IDW'(i) == sel) sel_div = bus.div_req[i*CLK_DIV_SIZE +: CLK_DIV_SIZE];
  end

  assign owner_req   = bus.req[owner_id];
  assign owner_rel   = bus.rel[owner_id];
  assign settle_done = bus.div_tick && (settle_cnt == 3'(SETTLE_TICKS - 1));

`ifdef CLK_DIV_ARB_LEASE_EN
  localparam int LW = $clog2(LEASE_TICKS + 1);
  logic [LW-1:0] lease_cnt;
  logic          others;

  assign others     = |(bus.req & ~NUM_REQ'(one_hot(3'(owner_id))));
  assign lease_done = (state == OWNED) && bus.div_tick && others &&
                      (lease_cnt == LW'(LEASE_TICKS - 1));

  // Held at zero outside OWNED, so every ownership starts a fresh lease.
  always_ff @(posedge clk) begin
    if (!rst_n || state != OWNED) lease_cnt <= '0;
    else if (bus.div_tick && others) lease_cnt <= lease_cnt + LW'(1);
  end
`else
  assign lease_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner_id   <= '0;
      cur_div    <= '0;
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;
      // cur_div tracks div_out, which the WRITE cycle presents to the divider.
      if (state == IDLE && pick_valid) begin
        owner_id <= sel;
        rr_ptr   <= (int'(sel) == NUM_REQ - 1) ? '0 : sel + IDW'(1);
        cur_div  <= sel_div;
      end
      if (state == WRITE) settle_cnt <= '0;
      else if (state == SETTLE && bus.div_tick) settle_cnt <= settle_cnt + 3'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = (sel_div == cur_div) ? OWNED : WRITE;
      WRITE:   state_nxt = owner_req ? SETTLE : IDLE;
      SETTLE:  if (!owner_req) state_nxt = IDLE;
               else if (settle_done) state_nxt = OWNED;
      OWNED:   if (owner_rel || !owner_req || lease_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The write strobe is masked by reset so an in-flight WRITE never reaches the divider.
  always_comb begin
    bus.div_wr   = rst_n && (state == WRITE);
    bus.ready    = (state == OWNED);
    bus.grant    = (state != IDLE) ? NUM_REQ'(one_hot(3'(owner_id))) : '0;
    bus.div_out  = cur_div;
    bus.owner_id = owner_id;
  end

endmodule

// File: tb/tb_clk_div_cfg_arbiter.sv
// tb/tb_clk_div_cfg_arbiter.sv - directed-vector bench for clk_div_cfg_arbiter
module tb_clk_div_cfg_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  clk_div_cfg_arbiter_if #(.NUM_REQ(4), .CLK_DIV_SIZE(3)) bus ();

  clk_div_cfg_arbiter #(
    .NUM_REQ(4), .CLK_DIV_SIZE(3), .SETTLE_TICKS(1), .LEASE_TICKS(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input int i, input int v);
    logic [2:0] v3;
    v3 = v[2:0];
    bus.div_req[i*3 +: 3] = v3;
  endtask

  initial begin
    bus.req = '0; bus.rel = '0; bus.div_req = '0; bus.div_tick = 1'b0;
    rst_n = 1'b0;
    step(); step();
    check("rst_grant", bus.grant, 0);
    check("rst_ready", bus.ready, 0);
    check("rst_div_wr", bus.div_wr, 0);
    check("rst_div_out", bus.div_out, 0);
    check("rst_owner", bus.owner_id, 0);

    rst_n = 1'b1;
    set_div(1, 3); bus.req = 4'b0010;
    step();
    check("g1_grant", bus.grant, 4'b0010);
    check("g1_owner", bus.owner_id, 1);
    check("g1_div_wr", bus.div_wr, 1);
    check("g1_div_out", bus.div_out, 3);
    check("g1_ready", bus.ready, 0);
    bus.div_tick = 1'b1; step(); bus.div_tick = 1'b0;
    check("g1_wr_pulse_end", bus.div_wr, 0);
    check("g1_settle_ready", bus.ready, 0);
    step();
    check("tick_in_write_ignored", bus.ready, 0);
    bus.div_tick = 1'b1; step(); bus.div_tick = 1'b0;
    check("g1_ready_after_tick", bus.ready, 1);
    check("g1_grant_held", bus.grant, 4'b0010);

    set_div(3, 3); set_div(0, 3);
    bus.req = 4'b1011; bus.rel = 4'b0010;
    step(); bus.rel = '0;
    check("rel_gap_grant", bus.grant, 0);
    check("rel_gap_ready", bus.ready, 0);
    step();
    check("rr_grant_3", bus.grant, 4'b1000);
    check("rr_owner_3", bus.owner_id, 3);
    check("match_ready", bus.ready, 1);
    check("match_no_wr", bus.div_wr, 0);

    set_div(0, 6);
    bus.req = 4'b1001; bus.rel = 4'b1000;
    step(); bus.rel = '0;
    check("rel_wins_grant", bus.grant, 0);
    step();
    check("rr_grant_0", bus.grant, 4'b0001);
    check("g0_div_wr", bus.div_wr, 1);
    check("g0_div_out", bus.div_out, 6);
    step();
    bus.req = 4'b0000;
    step();
    check("abort_grant", bus.grant, 0);
    check("abort_ready", bus.ready, 0);
    check("abort_div_out", bus.div_out, 6);
    step();
    check("idle_ready", bus.ready, 0);

    set_div(2, 1); bus.req = 4'b0100;
    step();
    check("pre_rst_div_wr", bus.div_wr, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_write_wr", bus.div_wr, 0);
    step();
    check("rst2_grant", bus.grant, 0);
    check("rst2_div_out", bus.div_out, 0);
    check("rst2_owner", bus.owner_id, 0);
    check("rst2_div_wr", bus.div_wr, 0);

    set_div(0, 0); bus.req = 4'b0101;
    rst_n = 1'b1;
    step();
    check("post_rst_grant", bus.grant, 4'b0001);
    check("post_rst_ready", bus.ready, 1);
    check("post_rst_no_wr", bus.div_wr, 0);

    bus.rel = 4'b0100;
    step(); bus.rel = '0;
    check("nonowner_rel", bus.grant, 4'b0001);
    set_div(0, 7);
    step();
    check("div_change_no_wr", bus.div_wr, 0);
    check("div_change_out", bus.div_out, 0);
    check("div_change_ready", bus.ready, 1);

    for (int i = 0; i < 15; i++) begin
      bus.div_tick = 1'b1; step();
    end
    bus.div_tick = 1'b0;
    check("lease_15_held", bus.grant, 4'b0001);
    bus.div_tick = 1'b1; step(); bus.div_tick = 1'b0;
`ifdef CLK_DIV_ARB_LEASE_EN
    check("lease_release_grant", bus.grant, 0);
    check("lease_release_ready", bus.ready, 0);
    step();
    check("lease_next_owner", bus.grant, 4'b0100);
`else
    check("no_lease_16", bus.grant, 4'b0001);
    for (int i = 0; i < 84; i++) begin
      bus.div_tick = 1'b1; step();
    end
    bus.div_tick = 1'b0;
    check("no_lease_100", bus.grant, 4'b0001);
    check("no_lease_ready", bus.ready, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_div_cfg_arbiter.md
Name: clk_div_cfg_arbiter

Overview:
Shares one clock_divider instance between NUM_REQ requesters, each wanting a specific divide setting.
- Round-robin arbitration picks one requester.
- The block issues the divider write (wr pulse plus div value) and waits for the divider's output ticks to settle.
- It then signals ready to the owner and holds ownership until release.
- It sits between peripheral blocks (PWM and similar) and the divider's wr/div_in/clk_out pins.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
CLK_DIV_SIZE, 3, width of divide code; must match the divider.
SETTLE_TICKS, 1, div_tick pulses counted after a write before ready (1..7).
LEASE_TICKS, 16, max div_tick pulses per ownership while others wait (used only with the optional feature).

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous, active-low reset.
req  in  NUM_REQ  level request per requester.
rel  in  NUM_REQ  one-cycle release pulse per requester.
div_req  in  NUM_REQ*CLK_DIV_SIZE  requested divide code; requester i at bits [i*CLK_DIV_SIZE +: CLK_DIV_SIZE].
div_tick  in  1  divider clk_out pulse.
div_wr  out  1  one-cycle write strobe to divider wr.
div_out  out  CLK_DIV_SIZE  divide code to divider div_in; holds the last programmed value.
grant  out  NUM_REQ  one-hot current owner, 0 when idle.
ready  out  1  divider settled at owner's setting.
owner_id  out  $clog2(NUM_REQ)  index of current or last owner.

Behaviour:
- Reset values: div_wr=0, div_out=0, grant=0, ready=0, owner_id=0, rr_ptr=0, settle_cnt=0, state=IDLE, cur_div=0.
  - cur_div=0 matches the divider's reset state.
- States: IDLE, WRITE, SETTLE, OWNED.
- IDLE:
  - If any req bit is set, select the first set bit searching from rr_ptr upward, wrapping at NUM_REQ.
  - Next cycle: grant[sel]=1, owner_id=sel, rr_ptr=(sel+1) mod NUM_REQ.
  - If div_req[sel]==cur_div, go directly to OWNED with ready=1. There is no write.
  - Otherwise go to WRITE.
- WRITE (exactly 1 cycle):
  - div_wr=1, div_out=div_req[owner], cur_div updated, settle_cnt cleared.
  - Go to SETTLE.
- SETTLE:
  - Increment settle_cnt on each div_tick.
  - When the tick that makes settle_cnt==SETTLE_TICKS arrives, go to OWNED. ready=1 from the following cycle.
  - A div_tick in the same cycle as div_wr is not counted.
- OWNED:
  - ready=1 while in this state.
  - rel[owner]=1, or req[owner]=0, causes a transition to IDLE next cycle. grant=0 and ready=0 in that IDLE cycle.
  - Re-arbitration happens from IDLE, so at least one idle cycle separates owners.
- Abort: req[owner] dropping in WRITE or SETTLE returns to IDLE.
  - The written value stays programmed, and cur_div reflects it.
- Ignored inputs: rel bits of non-owners and rel in IDLE are ignored. A change of div_req[owner] while owned is ignored until the next grant.
- Simultaneous events: rel[owner] and a new req in the same cycle — the release wins, and the new req is arbitrated from IDLE next cycle.
- Reset mid-operation: all state returns to reset values immediately. No div_wr is emitted, even mid-WRITE.
- Latency: req to grant is 1 cycle from IDLE. req to ready is 1 cycle when the setting matches; otherwise 2 cycles + time to SETTLE_TICKS ticks.

Optional Feature:
CLK_DIV_ARB_LEASE_EN.
- Defined: in OWNED, a lease counter increments on each div_tick while any other req bit is set.
  - On reaching LEASE_TICKS, the owner is forcibly released: go to IDLE, grant=0, ready=0.
  - The counter clears on entering OWNED.
- Undefined: no lease counter. Ownership ends only by rel or req drop. LEASE_TICKS is unused.

Decomposition:
- Shared package clk_div_pkg:
  - state enum (IDLE, WRITE, SETTLE, OWNED);
  - CLK_DIV_SIZE default constant;
  - function for one-hot from index.
- One sub-module: rr_pick (round-robin first-set search from a pointer, combinational, NUM_REQ param). It is reused by future shared-resource arbiters.

Test Plan:
- Reset, then req=4'b0010, div_req[1]=3 -> grant=0010 next cycle; div_wr pulse with div_out=3 one cycle later; ready after 1 div_tick; owner_id=1.
- Owner 1 sends rel while req=4'b1011 pending -> IDLE for 1 cycle; next grant=1000 (rr_ptr=2, first set from 2 upward is 3); then 0001 after it releases.
- Grant to requester 0 with div_req[0]==cur_div=3 -> no div_wr; ready asserts the cycle after grant.
- req[owner] dropped during SETTLE -> grant=0, ready never asserts, div_out keeps the new value.
- rst_n=0 asserted during WRITE -> div_wr=0 next edge, all outputs at reset values, cur_div=0.
- With CLK_DIV_ARB_LEASE_EN, LEASE_TICKS=16: owner holds while another req is pending -> forced release after the 16th div_tick. Without the macro: no release after 100 ticks.
